dm_access_ctrl: RTL and testbench
=================================

Name: dm_access_ctrl

Overview:
- Sequences all traffic into the data memory block (load/store/push/pop strobes, 9-bit address, 16-bit stack address, 16-bit write data).
- Owns the stack pointer.
- Arbitrates between the CPU execute stage and a debug/loader port.
- Issues single-cycle memory strobes, waits out read latency, returns data with a one-cycle ack.

Parameters:
ADDR_W, 9, data memory word-address width
DATA_W, 16, data word width
SP_RESET, 512, stack pointer value after reset (empty stack; stack grows down)
SP_LIMIT, 256, lowest legal stack address; push at this SP overflows
READ_LAT, 1, cycles from load/pop strobe until dm_data_out is valid (1..4)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous reset, active-high
cpu_req  in  1  CPU request, held with operands until cpu_ack
cpu_op  in  2  00 load, 01 store, 10 push, 11 pop
cpu_addr  in  ADDR_W  load/store address
cpu_wdata  in  DATA_W  store/push data
cpu_ack  out  1  one-cycle completion pulse
cpu_rdata  out  DATA_W  load/pop data, valid with cpu_ack, held until next CPU read
cpu_err  out  1  stack overflow/underflow, valid with cpu_ack
dbg_req  in  1  debug request, held until dbg_ack
dbg_we  in  1  1 store, 0 load
dbg_addr  in  ADDR_W  debug address
dbg_wdata  in  DATA_W  debug write data
dbg_ack  out  1  one-cycle completion pulse
dbg_rdata  out  DATA_W  debug read data, valid with dbg_ack
dm_load, dm_store, dm_push, dm_pop  out  1 each  memory strobes
dm_address  out  ADDR_W  load/store address to memory
dm_sp  out  16  push/pop address to memory
dm_rez  out  DATA_W  write data to memory
dm_data_out  in  DATA_W  memory read data
sp  out  16  current stack pointer

Behaviour:
- Clocking/reset: one clock (clk); rst is synchronous and active-high.
- Reset values:
  - all acks, err, and dm_* strobes 0
  - dm_address, dm_sp, dm_rez, cpu_rdata, dbg_rdata 0
  - sp = SP_RESET
  - FSM = IDLE
  - arbitration pointer = CPU
- FSM: IDLE -> ISSUE -> (WAIT if load/pop) -> RESP -> IDLE.
- IDLE:
  - Samples cpu_req and dbg_req.
  - Both asserted: grant the requester the pointer favours; the pointer then flips to the other (round-robin).
  - One asserted: grant it; the pointer flips to the other requester.
  - Grant latches op, address, and data into internal registers.
- Stack checks at grant:
  - Push with sp == SP_LIMIT: overflow.
  - Pop with sp == SP_RESET: underflow.
  - Either case goes IDLE -> RESP directly: no strobe, sp unchanged, cpu_err = 1 with cpu_ack.
- ISSUE (1 cycle):
  - Exactly one dm_* strobe is high.
  - Push: dm_sp = sp-1, dm_rez = wdata.
  - Pop: dm_sp = sp.
  - Load/store: dm_address = addr; store also drives dm_rez.
  - dm_address, dm_sp, dm_rez stay stable from ISSUE through WAIT.
- WAIT: counts READ_LAT cycles. dm_data_out is captured on the last WAIT cycle into the granted requester's rdata register.
- RESP (1 cycle):
  - Granted requester's ack = 1.
  - sp updates on this edge: push sp-1, pop sp+1; unchanged on error or load/store.
- Latency from request sampled in IDLE to ack:
  - store/push: 2 cycles
  - load/pop: 2 + READ_LAT cycles
  - error: 1 cycle
- Handshake:
  - A requester must deassert req in the cycle after ack.
  - A req still high in IDLE after its ack is treated as a new request.
  - Changing operands while req is high and before ack has no effect (operands latched at grant).
- Simultaneous requests arriving while busy wait in IDLE and are not queued beyond the held req level.
- rst mid-operation: next edge forces IDLE, clears strobes, sp = SP_RESET; the aborted request gets no ack.
- sp arithmetic is 16-bit; the range is bounded by the SP_LIMIT/SP_RESET checks, so no wrap is possible.

Optional Feature:
- Macro: DM_ACCESS_CTRL_SP_SET_EN.
- With the macro defined:
  - Adds ports sp_set (in, 1) and sp_set_val (in, 16).
  - sp_set high in IDLE loads sp <= sp_set_val on that edge.
  - sp_set takes precedence over granting a request that cycle; the request is granted the following cycle.
  - sp_set outside IDLE is ignored.
- Without the macro: ports absent; sp changes only via reset, push, and pop.

Test Plan:
- Reset, then CPU store addr 0x001 data 0x1234 -> dm_store high exactly 1 cycle with dm_address 0x001, dm_rez 0x1234; cpu_ack 2 cycles after req; cpu_err 0.
- CPU load 0x001, memory returns 0x1234 after READ_LAT=1 -> cpu_ack 3 cycles after req, cpu_rdata 0x1234.
- Push 0x5678 from sp=512 -> dm_push with dm_sp 511, sp becomes 511. Pop -> dm_pop with dm_sp 511, cpu_rdata 0x5678, sp back to 512.
- Pop at sp=512 -> cpu_ack and cpu_err after 1 cycle, no dm strobe, sp 512. Push 256 times, then one more push -> 257th push sets cpu_err, sp stays 256.
- cpu_req and dbg_req asserted together, each re-requesting immediately after ack -> grants alternate CPU, DBG, CPU, DBG; each ack goes only to its owner.
- Assert rst during WAIT of a pop -> no cpu_ack, strobes 0, sp 512 next cycle. With DM_ACCESS_CTRL_SP_SET_EN: sp_set_val 0x0180 in IDLE -> sp 0x0180 next cycle.

Source files
------------

// File: rtl/dm_access_ctrl_if.sv
// Bus bundle for dm_access_ctrl: CPU port, debug/loader port, data-memory side and stack pointer.
// DM_ACCESS_CTRL_SP_SET_EN adds the sp_set/sp_set_val stack-pointer load inputs.
`timescale 1ns/1ps

interface dm_access_ctrl_if #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 16
) ();
  logic              cpu_req;
  logic [1:0]        cpu_op;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_err;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_ack;
  logic [DATA_W-1:0] dbg_rdata;

  logic              dm_load;
  logic              dm_store;
  logic              dm_push;
  logic              dm_pop;
  logic [ADDR_W-1:0] dm_address;
  logic [15:0]       dm_sp;
  logic [DATA_W-1:0] dm_rez;
  logic [DATA_W-1:0] dm_data_out;

  logic [15:0]       sp;

`ifdef DM_ACCESS_CTRL_SP_SET_EN
  logic              sp_set;
  logic [15:0]       sp_set_val;
`endif

  // Controller side
  modport slave (
`ifdef DM_ACCESS_CTRL_SP_SET_EN
    input  sp_set,
    input  sp_set_val,
`endif
    input  cpu_req, cpu_op, cpu_addr, cpu_wdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dm_data_out,
    output cpu_ack, cpu_rdata, cpu_err,
    output dbg_ack, dbg_rdata,
    output dm_load, dm_store, dm_push, dm_pop, dm_address, dm_sp, dm_rez,
    output sp
  );

  // Requester / memory side
  modport master (
`ifdef DM_ACCESS_CTRL_SP_SET_EN
    output sp_set,
    output sp_set_val,
`endif
    output cpu_req, cpu_op, cpu_addr, cpu_wdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dm_data_out,
    input  cpu_ack, cpu_rdata, cpu_err,
    input  dbg_ack, dbg_rdata,
    input  dm_load, dm_store, dm_push, dm_pop, dm_address, dm_sp, dm_rez,
    input  sp
  );
endinterface

// File: rtl/dm_access_ctrl.sv
// Data-memory access sequencer: round-robin CPU/debug arbitration, stack pointer ownership,
// single-cycle strobes and read-latency wait. Optional macro: DM_ACCESS_CTRL_SP_SET_EN.
`timescale 1ns/1ps

module dm_access_ctrl #(
  parameter int unsigned ADDR_W   = 9,
  parameter int unsigned DATA_W   = 16,
  parameter logic [15:0] SP_RESET = 16'd512,
  parameter logic [15:0] SP_LIMIT = 16'd256,
  parameter int unsigned READ_LAT = 1
) (
  input logic             clk,
  input logic             rst,
  dm_access_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  localparam logic [1:0] OpLoad  = 2'b00;
  localparam logic [1:0] OpStore = 2'b01;
  localparam logic [1:0] OpPush  = 2'b10;
  localparam logic [1:0] OpPop   = 2'b11;

  state_e            r_state;
  state_e            w_state_d;
  logic              r_ptr_dbg;
  logic              r_gnt_dbg;
  logic              r_err;
  logic [1:0]        r_op;
  logic [1:0]        r_wait_cnt;
  logic [15:0]       r_sp;
  logic [ADDR_W-1:0] r_dm_address;
  logic [15:0]       r_dm_sp;
  logic [DATA_W-1:0] r_dm_rez;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_dbg_rdata;

  logic              w_sp_set;
  logic              w_sel_dbg;
  logic              w_grant;
  logic              w_stack_err;
  logic              w_is_read;
  logic [1:0]        w_op;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_cpu_ack;
  logic              w_dbg_ack;
  logic              w_cpu_err;
  logic              w_issue;

`ifdef DM_ACCESS_CTRL_SP_SET_EN
  assign w_sp_set = bus.sp_set;
`else
  assign w_sp_set = 1'b0;
`endif

  // Debug port maps onto load/store; it can never push or pop.
  always_comb begin
    w_sel_dbg   = bus.dbg_req && (!bus.cpu_req || r_ptr_dbg);
    w_op        = w_sel_dbg ? {1'b0, bus.dbg_we} : bus.cpu_op;
    w_addr      = w_sel_dbg ? bus.dbg_addr : bus.cpu_addr;
    w_wdata     = w_sel_dbg ? bus.dbg_wdata : bus.cpu_wdata;
    w_stack_err = ((w_op == OpPush) && (r_sp == SP_LIMIT)) ||
                  ((w_op == OpPop) && (r_sp == SP_RESET));
    w_is_read   = (r_op == OpLoad) || (r_op == OpPop);
  end

  always_comb begin
    w_state_d = r_state;
    w_grant   = 1'b0;
    w_cpu_ack = 1'b0;
    w_dbg_ack = 1'b0;
    w_cpu_err = 1'b0;
    w_issue   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (!w_sp_set && (bus.cpu_req || bus.dbg_req)) begin
          w_grant   = 1'b1;
          w_state_d = w_stack_err ? StResp : StIssue;
        end
      end
      StIssue: begin
        w_issue   = 1'b1;
        w_state_d = w_is_read ? StWait : StResp;
      end
      StWait: begin
        if (r_wait_cnt == 2'd0) w_state_d = StResp;
      end
      StResp: begin
        w_cpu_ack = !r_gnt_dbg;
        w_dbg_ack = r_gnt_dbg;
        w_cpu_err = !r_gnt_dbg && r_err;
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr_dbg    <= 1'b0;
      r_gnt_dbg    <= 1'b0;
      r_err        <= 1'b0;
      r_op         <= OpLoad;
      r_wait_cnt   <= 2'd0;
      r_sp         <= SP_RESET;
      r_dm_address <= '0;
      r_dm_sp      <= 16'd0;
      r_dm_rez     <= '0;
      r_cpu_rdata  <= '0;
      r_dbg_rdata  <= '0;
    end else begin
`ifdef DM_ACCESS_CTRL_SP_SET_EN
      if ((r_state == StIdle) && bus.sp_set) r_sp <= bus.sp_set_val;
`endif
      if (w_grant) begin
        r_gnt_dbg <= w_sel_dbg;
        r_ptr_dbg <= !w_sel_dbg;
        r_op      <= w_op;
        r_err     <= w_stack_err;
        if (!w_stack_err) begin
          unique case (w_op)
            OpLoad:  r_dm_address <= w_addr;
            OpStore: begin
              r_dm_address <= w_addr;
              r_dm_rez     <= w_wdata;
            end
            OpPush: begin
              r_dm_sp  <= r_sp - 16'd1;
              r_dm_rez <= w_wdata;
            end
            OpPop:   r_dm_sp <= r_sp;
            default: ;
          endcase
        end
      end

      if (r_state == StIssue) begin
        r_wait_cnt <= 2'(READ_LAT - 1);
      end else if ((r_state == StWait) && (r_wait_cnt != 2'd0)) begin
        r_wait_cnt <= r_wait_cnt - 2'd1;
      end

      if ((r_state == StWait) && (r_wait_cnt == 2'd0)) begin
        if (r_gnt_dbg) r_dbg_rdata <= bus.dm_data_out;
        else           r_cpu_rdata <= bus.dm_data_out;
      end

      // Stack errors enter RESP straight from IDLE and leave sp untouched.
      if ((w_state_d == StResp) && (r_state != StIdle) && (r_state != StResp)) begin
        if (r_op == OpPush)     r_sp <= r_sp - 16'd1;
        else if (r_op == OpPop) r_sp <= r_sp + 16'd1;
      end
    end
  end

  assign bus.dm_load    = w_issue && (r_op == OpLoad);
  assign bus.dm_store   = w_issue && (r_op == OpStore);
  assign bus.dm_push    = w_issue && (r_op == OpPush);
  assign bus.dm_pop     = w_issue && (r_op == OpPop);
  assign bus.dm_address = r_dm_address;
  assign bus.dm_sp      = r_dm_sp;
  assign bus.dm_rez     = r_dm_rez;
  assign bus.cpu_ack    = w_cpu_ack;
  assign bus.cpu_err    = w_cpu_err;
  assign bus.cpu_rdata  = r_cpu_rdata;
  assign bus.dbg_ack    = w_dbg_ack;
  assign bus.dbg_rdata  = r_dbg_rdata;
  assign bus.sp         = r_sp;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Scoreboard bench for dm_access_ctrl: drivers queue expected acks and strobes,
// independent negedge monitors pop and compare.
`timescale 1ns/1ps

module tb_dm_access_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dm_access_ctrl_if #(.ADDR_W(9), .DATA_W(16)) bus ();

  dm_access_ctrl #(
    .ADDR_W  (9),
    .DATA_W  (16),
    .SP_RESET(16'd512),
    .SP_LIMIT(16'd256),
    .READ_LAT(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  localparam logic [1:0] OpLoad  = 2'b00;
  localparam logic [1:0] OpStore = 2'b01;
  localparam logic [1:0] OpPush  = 2'b10;
  localparam logic [1:0] OpPop   = 2'b11;

  // strobe kinds as {load, store, push, pop}
  localparam logic [3:0] KLoad  = 4'b1000;
  localparam logic [3:0] KStore = 4'b0100;
  localparam logic [3:0] KPush  = 4'b0010;
  localparam logic [3:0] KPop   = 4'b0001;

  typedef struct {
    bit          is_dbg;
    bit          err;
    bit          chk_rdata;
    logic [15:0] rdata;
    logic [15:0] sp;
    int          lat;
    int          t0;
  } ack_t;

  typedef struct {
    logic [3:0]  kind;
    logic [8:0]  addr;
    logic [15:0] sp;
    logic [15:0] rez;
  } stb_t;

  ack_t ack_q[$];
  stb_t stb_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  logic [15:0] mem [0:511];
  logic [15:0] stk [0:1023];

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model with one cycle of read latency
  always @(posedge clk) begin
    if (bus.dm_store) mem[bus.dm_address] <= bus.dm_rez;
    if (bus.dm_push)  stk[bus.dm_sp[9:0]] <= bus.dm_rez;
    if (bus.dm_load)  bus.dm_data_out <= mem[bus.dm_address];
    if (bus.dm_pop)   bus.dm_data_out <= stk[bus.dm_sp[9:0]];
  end

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic void exp_stb(input logic [3:0] k, input logic [8:0] a,
                                  input logic [15:0] s, input logic [15:0] r);
    stb_t e;
    e.kind = k;
    e.addr = a;
    e.sp   = s;
    e.rez  = r;
    stb_q.push_back(e);
  endfunction

  always @(negedge clk) begin : mon_ack
    ack_t e;
    if (bus.cpu_ack || bus.dbg_ack) begin
      chk("ack_exclusive", 32'(bus.cpu_ack & bus.dbg_ack), 0);
      if (ack_q.size() == 0) begin
        chk("unexpected_ack", {bus.cpu_ack, bus.dbg_ack}, 0);
      end else begin
        e = ack_q.pop_front();
        chk("ack_owner_dbg", 32'(bus.dbg_ack), 32'(e.is_dbg));
        chk("cpu_err", 32'(bus.cpu_err), 32'(e.err));
        if (e.chk_rdata) chk("rdata", e.is_dbg ? bus.dbg_rdata : bus.cpu_rdata, e.rdata);
        chk("sp_at_ack", bus.sp, e.sp);
        if (e.lat > 0) chk("latency", cyc - e.t0, e.lat);
      end
    end
  end

  always @(negedge clk) begin : mon_stb
    stb_t e;
    logic [3:0] k;
    k = {bus.dm_load, bus.dm_store, bus.dm_push, bus.dm_pop};
    if (k != 4'b0000) begin
      if (stb_q.size() == 0) begin
        chk("unexpected_strobe", k, 0);
      end else begin
        e = stb_q.pop_front();
        chk("strobe_kind", k, e.kind);
        if (e.kind == KLoad || e.kind == KStore) chk("dm_address", bus.dm_address, e.addr);
        if (e.kind == KPush || e.kind == KPop)   chk("dm_sp", bus.dm_sp, e.sp);
        if (e.kind == KStore || e.kind == KPush) chk("dm_rez", bus.dm_rez, e.rez);
      end
    end
  end

  task automatic wait_ack(input bit is_dbg);
    bit got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = is_dbg ? bus.dbg_ack : bus.cpu_ack;
    end
    chk(is_dbg ? "dbg_ack_seen" : "cpu_ack_seen", 32'(got), 1);
    if (is_dbg) bus.dbg_req = 1'b0;
    else        bus.cpu_req = 1'b0;
  endtask

  task automatic txn(input bit is_dbg, input logic [1:0] op, input logic [8:0] a,
                     input logic [15:0] d, input bit mutate, input bit err, input bit chk_rd,
                     input logic [15:0] rd, input logic [15:0] sp_exp, input int lat);
    ack_t e;
    @(negedge clk);
    e.is_dbg    = is_dbg;
    e.err       = err;
    e.chk_rdata = chk_rd;
    e.rdata     = rd;
    e.sp        = sp_exp;
    e.lat       = lat;
    e.t0        = cyc;
    ack_q.push_back(e);
    if (is_dbg) begin
      bus.dbg_req = 1'b1; bus.dbg_we = op[0]; bus.dbg_addr = a; bus.dbg_wdata = d;
    end else begin
      bus.cpu_req = 1'b1; bus.cpu_op = op; bus.cpu_addr = a; bus.cpu_wdata = d;
    end
    if (mutate) begin
      @(negedge clk);
      bus.cpu_addr  = 9'h1FF;
      bus.cpu_wdata = 16'hFFFF;
    end
    wait_ack(is_dbg);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nc;
    int nd;
    bus.cpu_req = 0; bus.cpu_op = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
    bus.dbg_req = 0; bus.dbg_we = 0; bus.dbg_addr = 0; bus.dbg_wdata = 0;
    bus.dm_data_out = 0;
`ifdef DM_ACCESS_CTRL_SP_SET_EN
    bus.sp_set = 0; bus.sp_set_val = 0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_sp", bus.sp, 16'd512);
    chk("rst_strobes", {bus.dm_load, bus.dm_store, bus.dm_push, bus.dm_pop}, 0);
    chk("rst_acks_err", {bus.cpu_ack, bus.dbg_ack, bus.cpu_err}, 0);
    chk("rst_dm_regs", {bus.dm_address, bus.dm_sp, bus.dm_rez}, 0);
    chk("rst_rdata", {bus.cpu_rdata, bus.dbg_rdata}, 0);
    rst = 1'b0;

    // Store with operands changed after grant, then load back
    exp_stb(KStore, 9'h001, 0, 16'h1234);
    txn(0, OpStore, 9'h001, 16'h1234, 1, 0, 0, 0, 16'd512, 2);
    exp_stb(KLoad, 9'h001, 0, 0);
    txn(0, OpLoad, 9'h001, 0, 0, 0, 1, 16'h1234, 16'd512, 3);

    // Push then pop
    exp_stb(KPush, 0, 16'd511, 16'h5678);
    txn(0, OpPush, 0, 16'h5678, 0, 0, 0, 0, 16'd511, 2);
    exp_stb(KPop, 0, 16'd511, 0);
    txn(0, OpPop, 0, 0, 0, 0, 1, 16'h5678, 16'd512, 3);

    // Underflow: no strobe, rdata held
    txn(0, OpPop, 0, 0, 0, 1, 1, 16'h5678, 16'd512, 1);

    // Debug load leaves the pointer favouring the CPU
    exp_stb(KLoad, 9'h001, 0, 0);
    txn(1, OpLoad, 9'h001, 0, 0, 0, 1, 16'h1234, 16'd512, 3);

    // Round-robin with both requesters holding req
    exp_stb(KStore, 9'h010, 0, 16'hAAAA);
    exp_stb(KStore, 9'h020, 0, 16'hBBBB);
    exp_stb(KStore, 9'h010, 0, 16'hAAAA);
    exp_stb(KStore, 9'h020, 0, 16'hBBBB);
    for (int i = 0; i < 4; i++) begin
      ack_t e;
      e.is_dbg = (i % 2) == 1; e.err = 0; e.chk_rdata = 0; e.rdata = 0;
      e.sp = 16'd512; e.lat = 0; e.t0 = 0;
      ack_q.push_back(e);
    end
    @(negedge clk);
    bus.cpu_req = 1; bus.cpu_op = OpStore; bus.cpu_addr = 9'h010; bus.cpu_wdata = 16'hAAAA;
    bus.dbg_req = 1; bus.dbg_we = 1; bus.dbg_addr = 9'h020; bus.dbg_wdata = 16'hBBBB;
    nc = 0;
    nd = 0;
    for (int i = 0; i < 60 && (nc < 2 || nd < 2); i++) begin
      @(negedge clk);
      if (bus.cpu_ack) begin nc++; if (nc == 2) bus.cpu_req = 0; end
      if (bus.dbg_ack) begin nd++; if (nd == 2) bus.dbg_req = 0; end
    end
    bus.cpu_req = 0;
    bus.dbg_req = 0;
    chk("rr_cpu_acks", nc, 2);
    chk("rr_dbg_acks", nd, 2);

    exp_stb(KLoad, 9'h020, 0, 0);
    txn(0, OpLoad, 9'h020, 0, 0, 0, 1, 16'hBBBB, 16'd512, 3);
    exp_stb(KLoad, 9'h010, 0, 0);
    txn(1, OpLoad, 9'h010, 0, 0, 0, 1, 16'hAAAA, 16'd512, 3);

    // Reset during WAIT of a pop: no ack, sp back to reset value
    exp_stb(KPush, 0, 16'd511, 16'h1111);
    txn(0, OpPush, 0, 16'h1111, 0, 0, 0, 0, 16'd511, 2);
    exp_stb(KPop, 0, 16'd511, 0);
    @(negedge clk);
    bus.cpu_req = 1; bus.cpu_op = OpPop;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    bus.cpu_req = 0;
    @(negedge clk);
    chk("abort_sp", bus.sp, 16'd512);
    chk("abort_strobes", {bus.dm_load, bus.dm_store, bus.dm_push, bus.dm_pop}, 0);
    chk("abort_acks", {bus.cpu_ack, bus.dbg_ack}, 0);
    rst = 1'b0;

    // Fill the stack to the limit, then overflow
    for (int i = 0; i < 256; i++) begin
      exp_stb(KPush, 0, 16'(511 - i), 16'(i));
      txn(0, OpPush, 0, 16'(i), 0, 0, 0, 0, 16'(511 - i), 2);
    end
    txn(0, OpPush, 0, 16'hDEAD, 0, 1, 0, 0, 16'd256, 1);

`ifdef DM_ACCESS_CTRL_SP_SET_EN
    // sp_set wins over a same-cycle request; request granted next cycle
    begin
      ack_t e;
      exp_stb(KStore, 9'h005, 0, 16'h0055);
      @(negedge clk);
      e.is_dbg = 0; e.err = 0; e.chk_rdata = 0; e.rdata = 0;
      e.sp = 16'h0180; e.lat = 3; e.t0 = cyc;
      ack_q.push_back(e);
      bus.sp_set = 1; bus.sp_set_val = 16'h0180;
      bus.cpu_req = 1; bus.cpu_op = OpStore; bus.cpu_addr = 9'h005; bus.cpu_wdata = 16'h0055;
      @(negedge clk);
      bus.sp_set = 0;
      chk("sp_set_val", bus.sp, 16'h0180);
      wait_ack(0);
    end
`endif

    repeat (4) @(negedge clk);
    chk("ack_queue_drained", ack_q.size(), 0);
    chk("strobe_queue_drained", stb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
